// File: rtl/audio_delay_fx_pkg.sv
// Shared definitions for the audio delay/echo effect: control bits, FSM states, sample sum.
// Build option AUDIO_FX_SAT_EN makes sum() saturate instead of wrapping.
package audio_fx_pkg;

   localparam int unsigned CTRL_FREEZE = 0;
   localparam int unsigned CTRL_DRY_EN = 1;
   localparam int unsigned CTRL_WET_EN = 2;
   localparam int unsigned CTRL_FB_EN  = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_MIX  = 2'd2
   } fx_state_e;

   // Caller truncates the result to its sample width; the wrapping build relies on that.
   function automatic logic signed [31:0] sum(input logic signed [31:0] a,
                                              input logic signed [31:0] b,
                                              input int unsigned        width);
      logic signed [32:0] s_v;
`ifdef AUDIO_FX_SAT_EN
      logic signed [32:0] hi_v;
      logic signed [32:0] lo_v;
`endif
      s_v = 33'(a) + 33'(b);
`ifdef AUDIO_FX_SAT_EN
      hi_v = (33'sd1 <<< (width - 32'd1)) - 33'sd1;
      lo_v = -(33'sd1 <<< (width - 32'd1));
      if (s_v > hi_v) begin
         sum = hi_v[31:0];
      end else if (s_v < lo_v) begin
         sum = lo_v[31:0];
      end else begin
         sum = s_v[31:0];
      end
`else
      sum = s_v[31:0];
`endif
   endfunction

endpackage

// File: rtl/audio_delay_fx_if.sv
// Strobe/channel sample bus between the codec deserialiser/serialiser and the delay effect.
interface audio_delay_fx_if #(
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 4096,
   parameter int CHANNELS = 2
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int AW   = $clog2(DEPTH);

   logic                     sample_end;
   logic                     sample_req;
   logic [CH_W-1:0]          chan;
   logic signed [DATA_W-1:0] audio_input;
   logic signed [DATA_W-1:0] audio_output;
   logic [3:0]               control;
   logic [AW-1:0]            delay;
   logic                     overrun;

   modport master (
      output sample_end, sample_req, chan, audio_input, control, delay,
      input  audio_output, overrun
   );

   modport slave (
      input  sample_end, sample_req, chan, audio_input, control, delay,
      output audio_output, overrun
   );
endinterface

// File: rtl/audio_delay_ram.sv
// Delay-line storage for all channels: one write port, one registered read port, address {ch, ptr}.
module audio_delay_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 13,
   parameter int WORDS  = 8192
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_r [WORDS];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port; contents are never cleared
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem_r[raddr];
      end
   end
endmodule

// File: rtl/audio_delay_fx.sv
// Multi-channel delay/echo: per-channel circular delay line, dry/wet mix, optional feedback.
// Build option AUDIO_FX_SAT_EN selects saturating arithmetic for the mix and feedback word.
module audio_delay_fx
   import audio_fx_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int DEPTH      = 4096,
   parameter int CHANNELS   = 2,
   parameter int GAIN_SHIFT = 1
) (
   input logic              clk,
   input logic              reset,
   audio_delay_fx_if.slave  bus
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int AW   = $clog2(DEPTH);

   fx_state_e                state_r;
   fx_state_e                state_nx_s;
   logic                     accept_s;
   logic                     mix_s;
   logic                     drop_s;
   logic                     chan_ok_s;
   logic [AW-1:0]            d_in_s;

   logic [CH_W-1:0]          ch_r;
   logic signed [DATA_W-1:0] x_r;
   logic [AW-1:0]            d_r;
   logic [CH_W+AW-1:0]       raddr_r;

   logic [AW-1:0]            wr_ptr_r [CHANNELS];
   logic [AW:0]              fill_r   [CHANNELS];
   logic signed [DATA_W-1:0] mix_r    [CHANNELS];
   logic signed [DATA_W-1:0] audio_output_r;
   logic                     overrun_r;

   logic [DATA_W-1:0]        ram_q_s;
   logic signed [DATA_W-1:0] q_s;
   logic signed [DATA_W-1:0] wet_s;
   logic signed [DATA_W-1:0] dry_term_s;
   logic signed [DATA_W-1:0] wet_term_s;
   logic signed [DATA_W-1:0] mix_val_s;
   logic signed [DATA_W-1:0] wr_data_s;
   logic                     we_s;

   assign chan_ok_s = (int'(bus.chan) < CHANNELS);
   assign d_in_s    = (bus.delay == '0) ? AW'(1'b1) : bus.delay;
   assign drop_s    = bus.sample_end && chan_ok_s && (state_r != ST_IDLE);
   assign q_s       = ram_q_s;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      mix_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.sample_end && chan_ok_s) begin
               accept_s   = 1'b1;
               state_nx_s = ST_RD;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RD:   state_nx_s = ST_MIX;
         ST_MIX: begin
            mix_s      = 1'b1;
            state_nx_s = ST_IDLE;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Wet gating hides words older than what this channel has written since reset
   always_comb begin
      if ({1'b0, d_r} <= fill_r[ch_r]) begin
         wet_s = q_s >>> GAIN_SHIFT;
      end else begin
         wet_s = '0;
      end
      if (bus.control[CTRL_DRY_EN]) begin
         dry_term_s = x_r;
      end else begin
         dry_term_s = '0;
      end
      if (bus.control[CTRL_WET_EN]) begin
         wet_term_s = wet_s;
      end else begin
         wet_term_s = '0;
      end
      mix_val_s = DATA_W'(sum(32'(dry_term_s), 32'(wet_term_s), DATA_W));
      if (bus.control[CTRL_FB_EN]) begin
         wr_data_s = DATA_W'(sum(32'(x_r), 32'(wet_s), DATA_W));
      end else begin
         wr_data_s = x_r;
      end
      we_s = mix_s && !bus.control[CTRL_FREEZE];
   end

   // Datapath and per-channel state
   always_ff @(posedge clk) begin
      if (reset) begin
         ch_r           <= '0;
         x_r            <= '0;
         d_r            <= '0;
         raddr_r        <= '0;
         audio_output_r <= '0;
         overrun_r      <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr_r[c] <= '0;
            fill_r[c]   <= '0;
            mix_r[c]    <= '0;
         end
      end else begin
         if (accept_s) begin
            ch_r    <= bus.chan;
            x_r     <= bus.audio_input;
            d_r     <= d_in_s;
            raddr_r <= {bus.chan, wr_ptr_r[bus.chan] - d_in_s};
         end
         if (mix_s) begin
            mix_r[ch_r] <= mix_val_s;
            if (!bus.control[CTRL_FREEZE]) begin
               wr_ptr_r[ch_r] <= wr_ptr_r[ch_r] + AW'(1'b1);
               if (fill_r[ch_r] != (AW + 1)'(DEPTH)) begin
                  fill_r[ch_r] <= fill_r[ch_r] + (AW + 1)'(1'b1);
               end
            end
         end
         if (drop_s) begin
            overrun_r <= 1'b1;
         end
         if (bus.sample_req && chan_ok_s) begin
            audio_output_r <= mix_r[bus.chan];
         end
      end
   end

   audio_delay_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (CH_W + AW),
      .WORDS  (CHANNELS * DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (we_s),
      .waddr ({ch_r, wr_ptr_r[ch_r]}),
      .wdata (wr_data_s),
      .re    (state_r == ST_RD),
      .raddr (raddr_r),
      .rdata (ram_q_s)
   );

   assign bus.audio_output = audio_output_r;
   assign bus.overrun      = overrun_r;
endmodule

// File: tb/tb_audio_delay_fx.sv
// Directed bench for audio_delay_fx (DEPTH=8, 2 channels, GAIN_SHIFT=1) with a request scoreboard.
module tb_audio_delay_fx;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int CHS    = 2;

`ifdef AUDIO_FX_SAT_EN
   localparam logic [15:0] FB_MIX2 = 16'h7FFF;
   localparam logic [15:0] FB_WORD = 16'h3FFF;
`else
   localparam logic [15:0] FB_MIX2 = 16'h9000;
   localparam logic [15:0] FB_WORD = 16'hC800;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] exp_q [$];
   string       name_q [$];

   audio_delay_fx_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CHANNELS(CHS)) bus ();

   audio_delay_fx #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .CHANNELS(CHS), .GAIN_SHIFT(1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Monitor: every request edge pops one expected sample
   always @(posedge clk) begin
      logic [15:0] exp_v;
      string       nm_v;
      if (bus.sample_req === 1'b1) begin
         @(negedge clk);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: got %h, nothing expected", bus.audio_output);
         end else begin
            exp_v = exp_q.pop_front();
            nm_v  = name_q.pop_front();
            if (bus.audio_output !== exp_v) begin
               errors++;
               $display("FAIL %s: got %h expected %h", nm_v, bus.audio_output, exp_v);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset(input string nm);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check({nm, "_out"}, bus.audio_output, 16'h0000);
      check({nm, "_ovr"}, {15'd0, bus.overrun}, 16'h0000);
   endtask

   task automatic strobe(input logic ch, input logic [15:0] x);
      bus.chan        = ch;
      bus.audio_input = x;
      bus.sample_end  = 1'b1;
      @(negedge clk);
      bus.sample_end  = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic request(input logic ch, input logic [15:0] exp, input string nm);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      bus.chan       = ch;
      bus.sample_req = 1'b1;
      @(negedge clk);
      bus.sample_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic strobe_req(input logic ch, input logic [15:0] x, input logic [15:0] exp,
                             input string nm);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      bus.chan        = ch;
      bus.audio_input = x;
      bus.sample_end  = 1'b1;
      bus.sample_req  = 1'b1;
      @(negedge clk);
      bus.sample_end  = 1'b0;
      bus.sample_req  = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      bus.sample_end  = 1'b0;
      bus.sample_req  = 1'b0;
      bus.chan        = 1'b0;
      bus.audio_input = 16'h0000;
      bus.control     = 4'b0000;
      bus.delay       = 3'd1;
      @(negedge clk);

      // Dry pass, including a request in the same cycle as a new sample
      do_reset("rst1");
      bus.control = 4'b0010;
      strobe(1'b0, 16'h1234);
      request(1'b0, 16'h1234, "dry");
      strobe_req(1'b0, 16'h5678, 16'h1234, "same_cycle_prev");
      request(1'b0, 16'h5678, "dry2");
      bus.control = 4'b0000;
      strobe(1'b0, 16'h1234);
      request(1'b0, 16'h0000, "dry_off");

      // Echo timing
      do_reset("rst2");
      bus.control = 4'b0100;
      bus.delay   = 3'd3;
      strobe(1'b0, 16'h4000); request(1'b0, 16'h0000, "echo0");
      strobe(1'b0, 16'h0000); request(1'b0, 16'h0000, "echo1");
      strobe(1'b0, 16'h0000); request(1'b0, 16'h0000, "echo2");
      strobe(1'b0, 16'h0000); request(1'b0, 16'h2000, "echo3");

      // Feedback with saturating or wrapping sum
      do_reset("rst3");
      bus.control = 4'b1110;
      bus.delay   = 3'd1;
      strobe(1'b0, 16'h6000); request(1'b0, 16'h6000, "fb1");
      strobe(1'b0, 16'h6000); request(1'b0, FB_MIX2,  "fb2");
      bus.control = 4'b0100;
      strobe(1'b0, 16'h0000); request(1'b0, FB_WORD,  "fb_word");

      // Channel isolation
      do_reset("rst4");
      bus.control = 4'b0100;
      bus.delay   = 3'd2;
      for (int k = 0; k < 4; k++) begin
         strobe(1'b0, 16'(16'h0100 * (k + 1)));
         request(1'b0, (k >= 2) ? 16'(16'h0080 * (k - 1)) : 16'h0000, $sformatf("iso_l%0d", k));
         strobe(1'b1, 16'(16'h0F00 - 16'h0100 * k));
         request(1'b1, (k >= 2) ? 16'((16'h0F00 - 16'h0100 * (k - 2)) >> 1) : 16'h0000,
                 $sformatf("iso_r%0d", k));
      end

      // Pointer wrap, then freeze
      do_reset("rst5");
      bus.control = 4'b0100;
      bus.delay   = 3'd7;
      for (int n = 0; n < 10; n++) begin
         strobe(1'b0, 16'(16'h0010 * (n + 1)));
         request(1'b0, (n >= 7) ? 16'(16'h0008 * (n - 6)) : 16'h0000, $sformatf("wrap%0d", n));
      end
      bus.control = 4'b0101;
      for (int f = 0; f < 3; f++) begin
         strobe(1'b0, 16'h7777);
         request(1'b0, 16'h0020, $sformatf("freeze%0d", f));
      end
      bus.control = 4'b0100;
      bus.delay   = 3'd0;
      strobe(1'b0, 16'h00B0); request(1'b0, 16'h0050, "unfreeze_d0");
      bus.delay   = 3'd1;
      strobe(1'b0, 16'h0000); request(1'b0, 16'h0058, "unfreeze_d1");

      // Overrun: second strobe one cycle after the first is dropped
      do_reset("rst6");
      bus.control     = 4'b0100;
      bus.delay       = 3'd1;
      bus.chan        = 1'b0;
      bus.audio_input = 16'h2000;
      bus.sample_end  = 1'b1;
      @(negedge clk);
      bus.audio_input = 16'h7000;
      @(negedge clk);
      bus.sample_end  = 1'b0;
      @(negedge clk);
      check("overrun_set", {15'd0, bus.overrun}, 16'h0001);
      @(negedge clk);
      strobe(1'b0, 16'h0000); request(1'b0, 16'h1000, "ovr_echo");
      strobe(1'b0, 16'h0000); request(1'b0, 16'h0000, "ovr_not_written");
      check("overrun_sticky", {15'd0, bus.overrun}, 16'h0001);
      bus.control = 4'b0010;
      strobe(1'b0, 16'h4000); request(1'b0, 16'h4000, "pre_reset");

      // Reset while in MIX
      bus.audio_input = 16'h1234;
      bus.sample_end  = 1'b1;
      @(negedge clk);
      bus.sample_end  = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mixrst_out", bus.audio_output, 16'h0000);
      check("mixrst_ovr", {15'd0, bus.overrun}, 16'h0000);
      request(1'b0, 16'h0000, "mixrst_mix");
      bus.control = 4'b0100;
      strobe(1'b0, 16'h1111); request(1'b0, 16'h0000, "mixrst_gated");

      repeat (4) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d left, 0 required", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
